// File: rtl/exec_controller_if.sv
// exec_controller_if: host load stream, imem write port and core control/observe signals
interface exec_controller_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 15,
  parameter int CNT_W   = 16
);
  logic               load_start;
  logic [7:0]         load_len;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               run;
  logic               step;
  logic               halt_req;
  logic               bp_en;
  logic [ADDR_W-1:0]  bp_addr;
  logic [ADDR_W-1:0]  pc_addr;
  logic               cpu_en;
  logic               cpu_reset;
  logic [1:0]         state;
  logic [CNT_W-1:0]   cycle_count;
  modport master (
    output load_start, load_len, byte_valid, byte_data, run, step, halt_req, bp_en, bp_addr, pc_addr,
    input  byte_ready, imem_we, imem_waddr, imem_wdata, cpu_en, cpu_reset, state, cycle_count
  );
  modport slave (
    input  load_start, load_len, byte_valid, byte_data, run, step, halt_req, bp_en, bp_addr, pc_addr,
    output byte_ready, imem_we, imem_waddr, imem_wdata, cpu_en, cpu_reset, state, cycle_count
  );
endinterface

// File: rtl/exec_controller.sv
// exec_controller: program loader and run/step/halt sequencer owning the core enable and reset
module exec_controller #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 15,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset,
  exec_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, HALTED = 2'b11} state_t;
  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic               first_q, first_d;
  logic               we_q, we_d;
  logic [6:0]         hold_q, hold_d;
  logic [7:0]         len_q, len_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               loading, bp_hit, en;
  always_comb begin
    loading = state_q == LOAD;
    bp_hit  = bus.bp_en && bus.pc_addr == bus.bp_addr && !first_q;
    en = (state_q == RUN) ? !bp_hit && !bus.halt_req
       : !loading && bus.step && !bus.run && !bus.load_start;
    state_d = state_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    first_d = 1'b0;
    cnt_d   = (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    if (loading) begin
      if (bus.byte_valid) begin
        phase_d = !phase_q;
        if (!phase_q) begin
          hold_d = bus.byte_data[6:0];
        end else begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = INSTR_W'({hold_q, bus.byte_data});
          idx_d   = idx_q + 1'b1;
          // len 0 wraps to 255 here, giving a 256-instruction load
          state_d = (idx_q == ADDR_W'(len_q - 8'd1)) ? IDLE : LOAD;
        end
      end
    end else if (state_q == RUN) begin
      state_d = en ? RUN : HALTED;
    end else if (bus.load_start) begin
      state_d = LOAD;
      idx_d   = '0;
      phase_d = 1'b0;
      cnt_d   = '0;
      len_d   = bus.load_len;
    end else if (bus.run) begin
      state_d = RUN;
      first_d = 1'b1;
    end else if (bus.step) begin
      state_d = HALTED;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      first_q <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      first_q <= first_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.byte_ready  = loading;
  assign bus.cpu_reset   = loading;
  assign bus.cpu_en      = en;
  assign bus.imem_we     = we_q;
  assign bus.imem_waddr  = waddr_q;
  assign bus.imem_wdata  = wdata_q;
  assign bus.state       = state_q;
  assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: randomized scoreboard bench with a PC-counting core model
module tb_exec_controller;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] pc;
  int tests = 0, fails = 0, cnt_m = 0;
  int wq_addr[$], wq_data[$], hq_cnt[$], hq_pc[$];
  logic [7:0] ldb[$];
  logic [1:0] prev_state;
  logic prev_en;
  always #5 clk = ~clk;
  exec_controller_if bus();
  exec_controller dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.pc_addr = pc;
  always @(posedge clk or posedge reset)
    if (reset || bus.cpu_reset) pc <= 8'd0;
    else if (bus.cpu_en) pc <= pc + 8'd1;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      prev_state = 2'b00;
      prev_en = 1'b0;
    end else begin
      if (bus.imem_we) begin
        if (wq_addr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("waddr", int'(bus.imem_waddr), wq_addr.pop_front());
          chk("wdata", int'(bus.imem_wdata), wq_data.pop_front());
        end
      end
      if (bus.state == 2'b01) begin
        chk("load_byte_ready", int'(bus.byte_ready), 1);
        chk("load_cpu_reset", int'(bus.cpu_reset), 1);
        chk("load_cpu_en", int'(bus.cpu_en), 0);
      end
      if (bus.state == 2'b11 && (prev_state != 2'b11 || prev_en)) begin
        if (hq_cnt.size() == 0) chk("unexpected_halt", 1, 0);
        else begin
          chk("halt_count", int'(bus.cycle_count), hq_cnt.pop_front());
          chk("halt_pc", int'(pc), hq_pc.pop_front());
        end
      end
      prev_state = bus.state;
      prev_en = bus.cpu_en;
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic quiet();
    bus.load_start = 1'b0;
    bus.run = 1'b0;
    bus.step = 1'b0;
    bus.halt_req = 1'b0;
  endtask
  task automatic noise();
    bus.load_start = 1'($urandom);
    bus.run = 1'($urandom);
    bus.step = 1'($urandom);
    bus.halt_req = 1'($urandom);
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, int'(bus.state), 0);
    chk({tag, "_cpu_en"}, int'(bus.cpu_en), 0);
    chk({tag, "_cpu_reset"}, int'(bus.cpu_reset), 0);
    chk({tag, "_byte_ready"}, int'(bus.byte_ready), 0);
    chk({tag, "_imem_we"}, int'(bus.imem_we), 0);
    chk({tag, "_cycle_count"}, int'(bus.cycle_count), 0);
  endtask
  task automatic fill(input int n);
    ldb.delete();
    for (int i = 0; i < 2 * n; i++) ldb.push_back(8'($urandom));
  endtask
  task automatic do_load(input int len, input int gap, input int nbytes);
    int ninstr;
    ninstr = (len == 0) ? 256 : len;
    quiet();
    bus.load_start = 1'b1;
    bus.load_len = 8'(len);
    cyc();
    bus.load_start = 1'b0;
    cnt_m = 0;
    for (int i = 0; i < nbytes; i++) begin
      repeat (gap) begin
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'($urandom);
        noise();
        cyc();
      end
      bus.byte_valid = 1'b1;
      bus.byte_data = ldb[i];
      noise();
      if (i % 2 == 1) begin
        wq_addr.push_back(i / 2);
        wq_data.push_back(int'(ldb[i-1][6:0]) * 256 + int'(ldb[i]));
      end
      cyc();
    end
    bus.byte_valid = 1'b0;
    quiet();
    if (nbytes == 2 * ninstr) begin
      chk("post_load_state", int'(bus.state), 0);
      chk("post_load_cpu_reset", int'(bus.cpu_reset), 0);
      chk("post_load_byte_ready", int'(bus.byte_ready), 0);
      chk("post_load_count", int'(bus.cycle_count), 0);
    end
  endtask
  task automatic wait_halt(input int lim);
    for (int i = 0; i < lim && bus.state != 2'b11; i++) cyc();
    chk("reached_halt", int'(bus.state), 3);
  endtask
  task automatic run_seq(input bit use_bp, input logic [7:0] b, input bit use_halt, input int kh, input bit with_step);
    int kbp, n;
    kbp = use_bp ? ((int'(b) - int'(pc)) & 255) : 100000;
    if (kbp == 0) kbp = 256;
    n = (use_halt && kh <= kbp) ? kh : kbp;
    hq_cnt.push_back(cnt_m + n);
    hq_pc.push_back((int'(pc) + n) & 255);
    cnt_m += n;
    bus.bp_en = use_bp;
    bus.bp_addr = b;
    bus.run = 1'b1;
    bus.step = with_step;
    #1 chk("run_pulse_cpu_en", int'(bus.cpu_en), 0);
    cyc();
    bus.run = 1'b0;
    bus.step = 1'b0;
    if (use_halt && kh <= kbp) begin
      cyc(kh);
      bus.halt_req = 1'b1;
      #1 chk("halt_req_cpu_en", int'(bus.cpu_en), 0);
      cyc();
      bus.halt_req = 1'b0;
    end
    wait_halt(400);
  endtask
  task automatic do_step();
    hq_cnt.push_back(cnt_m + 1);
    hq_pc.push_back((int'(pc) + 1) & 255);
    cnt_m++;
    bus.bp_en = 1'b1;
    bus.bp_addr = pc;
    bus.step = 1'b1;
    #1 chk("step_cpu_en", int'(bus.cpu_en), 1);
    cyc();
    bus.step = 1'b0;
    chk("step_state", int'(bus.state), 3);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    quiet();
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'd0;
    bus.load_len = 8'd0;
    bus.bp_en = 1'b0;
    bus.bp_addr = 8'd0;
    reset = 1'b1;
    cyc(2);
    check_reset_vals("reset");
    chk("reset_waddr", int'(bus.imem_waddr), 0);
    chk("reset_wdata", int'(bus.imem_wdata), 0);
    reset = 1'b0;
    cyc();
    ldb = '{8'h92, 8'h34, 8'h7F, 8'hFF};
    do_load(2, 0, 4);
    cyc(2);
    do_load(2, 3, 4);
    cyc();
    run_seq(1'b1, 8'd3, 1'b0, 0, 1'b0);
    chk("bp_cycle_count", int'(bus.cycle_count), 3);
    chk("bp_pc", int'(pc), 3);
    do_step();
    chk("step_cycle_count", int'(bus.cycle_count), 4);
    run_seq(1'b0, 8'd0, 1'b1, 5, 1'b1);
    run_seq(1'b1, pc, 1'b0, 0, 1'b0);
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(2, 0))
        0: do_step();
        1: run_seq(1'($urandom), 8'($urandom), 1'b1, int'($urandom_range(20, 0)), 1'($urandom));
        default: begin
          fill(int'($urandom_range(6, 1)));
          do_load(ldb.size() / 2, int'($urandom_range(2, 0)), ldb.size());
        end
      endcase
      cyc(int'($urandom_range(2, 0)));
    end
    fill(256);
    do_load(0, 0, 512);
    cyc();
    run_seq(1'b1, 8'd7, 1'b0, 0, 1'b0);
    fill(4);
    do_load(4, 0, 3);
    reset = 1'b1;
    #1;
    check_reset_vals("midload");
    chk("midload_writes_left", wq_addr.size(), 0);
    cnt_m = 0;
    #2 reset = 1'b0;
    cyc();
    fill(3);
    do_load(3, 1, 6);
    cyc(2);
    chk("writes_drained", wq_addr.size(), 0);
    chk("halts_drained", hq_cnt.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
- Execution/debug sequencer that owns the computer's clock enable and reset.
- Loads a program into writable instruction memory from a byte stream with a valid/ready handshake.
- Runs, single-steps or halts the core, with one PC breakpoint.
- Sits between the host/test interface and the computer top: it drives the instruction-memory write port and the core enable/reset, and observes the core's program-counter address.

Parameters:
- ADDR_W, 8, instruction address width (matches the PC).
- INSTR_W, 15, instruction width: 7-bit opcode plus 8-bit literal.
- CNT_W, 16, width of the executed-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load_start  in  1  pulse; begin program load (honoured only in IDLE/HALTED).
- load_len  in  8  number of instructions to load, sampled with load_start; 0 means 256.
- byte_valid  in  1  load stream byte valid.
- byte_data  in  8  load stream byte.
- byte_ready  out  1  controller accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe.
- imem_waddr  out  ADDR_W  instruction memory write address.
- imem_wdata  out  INSTR_W  instruction memory write data.
- run  in  1  pulse; free-run from IDLE/HALTED.
- step  in  1  pulse; execute exactly one instruction from IDLE/HALTED.
- halt_req  in  1  pulse; stop a free run.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint PC.
- pc_addr  in  ADDR_W  current PC from the core.
- cpu_en  out  1  core clock enable (combinational from state and inputs).
- cpu_reset  out  1  core reset, high while in LOAD.
- state  out  2  IDLE=00, LOAD=01, RUN=10, HALTED=11.
- cycle_count  out  CNT_W  number of cycles with cpu_en=1; saturating.

Behaviour:
- Reset values:
  - state=IDLE; cpu_en=0; cpu_reset=0; byte_ready=0; imem_we=0; imem_waddr=0; imem_wdata=0; cycle_count=0.
  - Internal byte phase=0; instruction index=0; first-cycle flag=0.
- IDLE:
  - load_start goes to LOAD.
  - Otherwise run goes to RUN.
  - Otherwise step gives cpu_en=1 for that cycle only, and the next state is HALTED.
  - Priority: load_start > run > step. halt_req is ignored.
- LOAD:
  - On entry: index=0, phase=0, cycle_count cleared, load_len latched.
  - cpu_reset=1 and byte_ready=1 for the whole state; cpu_en=0.
  - A byte transfers when byte_valid && byte_ready.
  - Even byte (phase 0): byte_data[6:0] goes to a holding register (bit 7 ignored).
  - Odd byte (phase 1): in the next cycle imem_we=1 for exactly one cycle, with imem_waddr=index and imem_wdata={hold[6:0], byte}. index then increments.
  - After the odd byte of instruction load_len-1 is accepted, the next state is IDLE. The final imem_we pulse occurs in the first IDLE cycle; cpu_reset drops on the same edge.
  - run, step, halt_req and load_start are ignored while in LOAD.
  - Addresses not written keep their previous memory contents.
- RUN:
  - On entry the first-cycle flag is set; it clears after one cycle.
  - bp_hit = bp_en && pc_addr==bp_addr && !first.
  - cpu_en = !bp_hit && !halt_req.
  - bp_hit or halt_req goes to HALTED on that same edge, with the core not advanced. Both asserted together behave identically.
  - The first-cycle flag lets a run resume from a breakpoint PC.
  - load_start, run and step are ignored in RUN.
- HALTED:
  - Same transitions as IDLE.
  - A step executes one instruction even when pc_addr==bp_addr.
- cycle_count increments on every cycle with cpu_en=1 and saturates at all-ones.
- imem_we is never asserted outside the cycle after an odd byte.
- Reset mid-load:
  - Immediate return to IDLE with all outputs at reset values.
  - Memory keeps whatever was already written.
  - A pending write is dropped.

Test Plan:
- load_start with load_len=2, bytes 0x92,0x34,0x7F,0xFF, valid every cycle -> two imem_we pulses: addr 0 data 15'h1234, then addr 1 data 15'h7FFF. Then IDLE, cpu_reset low, byte_ready low.
- Load stream with byte_valid gaps of 3 cycles between bytes -> identical writes, no extra imem_we, byte_ready high throughout LOAD.
- After load, bp_en=1, bp_addr=3, run pulse, PC counts 0,1,2,3 -> cpu_en high for 3 cycles, state=HALTED with pc_addr=3, cycle_count=3.
- From that halt: step -> one cpu_en cycle, cycle_count=4, state stays HALTED. Then run -> cpu_en high in the first RUN cycle, continues past the breakpoint.
- In RUN, halt_req pulse -> cpu_en low in that cycle, state=HALTED next cycle. run and step asserted together from HALTED -> RUN.
- Assert reset after 3 bytes of a 4-instruction load -> state=IDLE, imem_we=0, cycle_count=0. A fresh load then writes from address 0.
